// File: rtl/uart_axis_rx.sv
// uart_axis_rx: 8N1 UART receiver producing an AXI4-Stream byte stream through a small FIFO
module uart_axis_rx #(
   parameter int          CLKS_PER_BIT = 868,
   parameter int          FIFO_AW      = 2,
   parameter logic [7:0]  EOL_CHAR     = 8'h0A
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_uart_rx,
   output logic [7:0] o_tdata,
   output logic       o_tlast,
   output logic       o_tvalid,
   input  logic       i_tready,
   output logic       o_frame_err,
   output logic       o_overrun
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULLB = CW'(CLKS_PER_BIT - 1);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
   state_t            state_q, state_d;
   logic              s1_q, rx_s_q;
   logic [CW-1:0]     baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic [8:0]        mem_q [2**FIFO_AW];
   logic [FIFO_AW:0]  wp_q, rp_q;
   logic              tick, push_req, ferr_d, empty, full, pop, do_push, ovr_d;
   logic              ferr_q, ovr_q;
   assign tick     = baud_q == '0;
   assign empty    = wp_q == rp_q;
   assign full     = (wp_q[FIFO_AW] != rp_q[FIFO_AW]) && (wp_q[FIFO_AW-1:0] == rp_q[FIFO_AW-1:0]);
   assign pop      = !empty && i_tready;
   assign do_push  = push_req && (!full || pop);
   assign ovr_d    = push_req && !do_push;
   assign o_tvalid = !empty;
   assign {o_tlast, o_tdata} = empty ? 9'd0 : mem_q[rp_q[FIFO_AW-1:0]];
   assign o_frame_err = ferr_q;
   assign o_overrun   = ovr_q;
   // two-flop synchroniser on the idle-high serial input
   always_ff @(posedge i_clk)
      if (i_rst) {rx_s_q, s1_q} <= 2'b11;
      else       {rx_s_q, s1_q} <= {s1_q, i_uart_rx};
   // receiver state, baud counter, bit index and shift register
   always_ff @(posedge i_clk)
      if (i_rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   // next state: half-bit delay to the start centre, then one full bit per sample
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      case (state_q)
         IDLE:  if (!rx_s_q) begin
                   baud_d  = HALF;
                   state_d = START;
                end
         START: if (!tick) baud_d = baud_q - 1'b1;
                else if (!rx_s_q) begin
                   baud_d  = FULLB;
                   bit_d   = '0;
                   state_d = DATA;
                end else state_d = IDLE;
         DATA:  if (!tick) baud_d = baud_q - 1'b1;
                else begin
                   shift_d = {rx_s_q, shift_q[7:1]};
                   baud_d  = FULLB;
                   bit_d   = bit_q + 1'b1;
                   state_d = bit_q == 3'd7 ? STOP : DATA;
                end
         STOP:  if (!tick) baud_d = baud_q - 1'b1;
                else state_d = rx_s_q ? IDLE : BRK;
         BRK:   if (rx_s_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // outputs of the FSM: push on a good stop bit, error on a bad one
   always_comb begin
      push_req = (state_q == STOP) && tick && rx_s_q;
      ferr_d   = (state_q == STOP) && tick && !rx_s_q;
   end
   // FIFO pointers wrap naturally; the extra MSB separates full from empty
   always_ff @(posedge i_clk)
      if (i_rst) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         wp_q <= wp_q + (FIFO_AW+1)'(do_push);
         rp_q <= rp_q + (FIFO_AW+1)'(pop);
      end
   // FIFO storage: byte plus end-of-line tag
   always_ff @(posedge i_clk)
      if (do_push) mem_q[wp_q[FIFO_AW-1:0]] <= {shift_q == EOL_CHAR, shift_q};
   // registered one-cycle error pulses
   always_ff @(posedge i_clk)
      if (i_rst) {ferr_q, ovr_q} <= 2'b00;
      else       {ferr_q, ovr_q} <= {ferr_d, ovr_d};
endmodule

// File: tb/tb_uart_axis_rx.sv
// tb_uart_axis_rx: scoreboard bench for the UART-to-stream receiver
module tb_uart_axis_rx;
   logic       clk = 0, rst = 1, rx = 1, tready = 0;
   logic [7:0] tdata;
   logic       tlast, tvalid, ferr, ovr;
   int         total = 0, bad = 0, cyc = 0;
   int         beats = 0, ferr_cnt = 0, ovr_cnt = 0, last_beat = 0, t_fall = 0;
   int         b0, f0, o0;
   logic [7:0] exp_q[$];
   logic [7:0] e, d;
   logic       hold_v = 0, done = 0;
   logic [8:0] hold_d = 0;

   uart_axis_rx #(.CLKS_PER_BIT(16), .FIFO_AW(2), .EOL_CHAR(8'h0A)) dut (
      .i_clk(clk), .i_rst(rst), .i_uart_rx(rx), .o_tdata(tdata), .o_tlast(tlast),
      .o_tvalid(tvalid), .i_tready(tready), .o_frame_err(ferr), .o_overrun(ovr));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic bitw(input logic v, input int n = 16);
      rx = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input logic stop);
      t_fall = cyc;
      bitw(1'b0);
      for (int i = 0; i < 8; i++) bitw(b[i]);
      bitw(stop);
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      check("drain_left", exp_q.size(), 0);
   endtask

   task automatic mark();
      b0 = beats; f0 = ferr_cnt; o0 = ovr_cnt;
   endtask

   // monitor: pops the scoreboard on every accepted beat and checks hold stability
   always @(negedge clk) begin
      if (rst) hold_v = 0;
      else begin
         if (hold_v) begin
            check("hold_valid", tvalid, 1);
            check("hold_data", {tlast, tdata}, hold_d);
         end
         check("err_excl", ferr && ovr, 0);
         ferr_cnt += ferr;
         ovr_cnt  += ovr;
         if (tvalid && tready) begin
            beats++;
            last_beat = cyc;
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_beat: got 0x%02h want none", tdata);
            end else begin
               e = exp_q.pop_front();
               check("tdata", tdata, e);
               check("tlast", tlast, e == 8'h0A);
            end
         end
         hold_v = tvalid && !tready;
         hold_d = {tlast, tdata};
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_tvalid", tvalid, 0);
      check("rst_tdata", tdata, 0);
      check("rst_tlast", tlast, 0);
      check("rst_ferr", ferr, 0);
      check("rst_ovr", ovr, 0);
      rst = 0;
      bitw(1'b1, 20);
      // single byte, latency bound
      tready = 1; mark();
      exp_q.push_back(8'h43); send(8'h43, 1'b1); drain();
      check("t1_beats", beats - b0, 1);
      check("t1_latency_ok", int'(last_beat - t_fall <= 160), 1);
      check("t1_ferr", ferr_cnt - f0, 0);
      check("t1_ovr", ovr_cnt - o0, 0);
      // end-of-line tagging
      mark();
      exp_q.push_back(8'h0A); send(8'h0A, 1'b1);
      exp_q.push_back(8'h41); send(8'h41, 1'b1); drain();
      check("t2_beats", beats - b0, 2);
      // back-pressure and overrun on the fifth byte
      tready = 0; mark();
      for (int i = 0; i < 5; i++) begin
         if (i < 4) exp_q.push_back(8'h31 + 8'(i));
         if (i == 4) check("t3_ovr_before", ovr_cnt - o0, 0);
         send(8'h31 + 8'(i), 1'b1);
      end
      check("t3_ovr_after", ovr_cnt - o0, 1);
      check("t3_ferr", ferr_cnt - f0, 0);
      check("t3_tvalid", tvalid, 1);
      check("t3_head", tdata, 8'h31);
      tready = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t3_drain_valid", tvalid, 1);
      end
      @(negedge clk);
      check("t3_drain_empty", tvalid, 0);
      drain();
      check("t3_beats", beats - b0, 4);
      // bad stop bit then a good frame
      mark();
      send(8'h55, 1'b0); bitw(1'b1, 32);
      check("t4_ferr", ferr_cnt - f0, 1);
      check("t4_nobeat", beats - b0, 0);
      exp_q.push_back(8'h55); send(8'h55, 1'b1); drain();
      check("t4_beats", beats - b0, 1);
      check("t4_ferr_once", ferr_cnt - f0, 1);
      // start-bit glitch rejected
      mark();
      bitw(1'b0, 4); bitw(1'b1, 32);
      check("t5_ferr", ferr_cnt - f0, 0);
      check("t5_nobeat", beats - b0, 0);
      exp_q.push_back(8'hC3); send(8'hC3, 1'b1); drain();
      check("t5_beats", beats - b0, 1);
      // reset mid-frame with a byte waiting in the FIFO
      tready = 0; mark();
      send(8'h5A, 1'b1); bitw(1'b1, 16);
      check("t6_pre_valid", tvalid, 1);
      d = 8'h96;
      bitw(1'b0);
      for (int i = 0; i < 4; i++) bitw(d[i]);
      bitw(d[4], 8);
      rst = 1; rx = 1;
      @(posedge clk); #1;
      rst = 0;
      check("t6_post_valid", tvalid, 0);
      tready = 1;
      bitw(1'b1, 32);
      exp_q.push_back(8'hA5); send(8'hA5, 1'b1); drain();
      check("t6_beats", beats - b0, 1);
      // random bytes with random back-pressure
      mark(); done = 0;
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               d = 8'($urandom);
               exp_q.push_back(d);
               send(d, 1'b1);
               bitw(1'b1, $urandom_range(1, 20));
            end
            done = 1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               tready = 1'($urandom_range(0, 1));
            end
         end
      join
      tready = 1;
      drain();
      check("rnd_beats", beats - b0, 10);
      check("rnd_ferr", ferr_cnt - f0, 0);
      check("rnd_ovr", ovr_cnt - o0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
